gravity_ticker: RTL

//  Drives the speed-bar display's interface from the producer side: it consumes gamespeed and

---
 rtl/tetris_pkg.sv | 22 ++
 rtl/bump_serializer.sv | 71 +++++++
 rtl/gravity_ticker.sv | 71 +++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// Shared widths, line-count clamp and bump FSM encoding for the gravity/bump logic.
package tetris_pkg;

  localparam int GS_W    = 24;
  localparam int LINES_W = 3;
  localparam logic [LINES_W-1:0] MAX_LINES = 3'd4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FIRE = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    FIRE = ST_FIRE,
    GAP  = ST_GAP
  } bump_state_t;

  function automatic logic [LINES_W-1:0] clamp_lines(input logic [LINES_W-1:0] n);
    return (n > MAX_LINES) ? MAX_LINES : n;
  endfunction

endpackage

// File: rtl/bump_serializer.sv
// Queues cleared lines and replays them as single-cycle bump pulses, BUMP_GAP+2 clocks apart.
// pause holds the train in IDLE/GAP; a FIRE cycle always completes.
module bump_serializer
  import tetris_pkg::*;
#(
  parameter int PEND_W   = 4,
  parameter int BUMP_GAP = 4
) (
  input  logic               clk_25_175,
  input  logic               reset,
  input  logic               pause,
  input  logic               lines_valid,
  input  logic [LINES_W-1:0] lines_cleared,
  output logic               bump,
  output logic [PEND_W-1:0]  bump_pending,
  output logic               overflow
);

  localparam int SUM_W = PEND_W + 2;
  localparam int GAP_W = (BUMP_GAP > 1) ? $clog2(BUMP_GAP) : 1;
  localparam logic [SUM_W-1:0] PEND_MAX = SUM_W'((1 << PEND_W) - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(BUMP_GAP - 1);

  bump_state_t       state;
  logic [PEND_W-1:0] pending;
  logic [GAP_W-1:0]  gap_cnt;
  logic              fire;
  logic [SUM_W-1:0]  sum;

  // The decrement lands on the same edge that raises bump, so bump_pending
  // already excludes the pulse currently on the wire.
  always_comb begin
    fire = (state == IDLE) && (pending != '0) && !pause;
    sum  = SUM_W'(pending)
         + (lines_valid ? SUM_W'(clamp_lines(lines_cleared)) : SUM_W'(0))
         - (fire ? SUM_W'(1) : SUM_W'(0));
  end

  always_ff @(posedge clk_25_175 or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pending  <= '0;
      gap_cnt  <= '0;
      bump     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (sum > PEND_MAX) begin
        pending  <= PEND_MAX[PEND_W-1:0];
        overflow <= 1'b1;
      end else begin
        pending <= sum[PEND_W-1:0];
      end
      bump <= fire;
      case (state)
        IDLE: if (fire) state <= FIRE;
        FIRE: begin
          state   <= GAP;
          gap_cnt <= '0;
        end
        GAP: if (!pause) begin
          if (gap_cnt == GAP_LAST) state <= IDLE;
          else                     gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bump_pending = pending;

endmodule

// File: rtl/gravity_ticker.sv
// Gravity timer emitting a drop_tick every effective period, plus the paced line-clear bump train.
// Period changes apply one cycle later; drop_tick and bump are registered and independent.
module gravity_ticker
  import tetris_pkg::*;
#(
  parameter int              SOFT_SHIFT = 4,
  parameter logic [GS_W-1:0] MIN_PERIOD = 24'd25175,
  parameter int              BUMP_GAP   = 4,
  parameter int              PEND_W     = 4
) (
  input  logic               clk_25_175,
  input  logic               reset,
  input  logic [GS_W-1:0]    gamespeed,
  input  logic               pause,
  input  logic               soft_drop,
  input  logic               piece_locked,
  input  logic               lines_valid,
  input  logic [LINES_W-1:0] lines_cleared,
  output logic               drop_tick,
  output logic               bump,
  output logic [PEND_W-1:0]  bump_pending,
  output logic               overflow
);

  logic [GS_W-1:0] sel_period;
  logic [GS_W-1:0] period;
  logic [GS_W-1:0] counter;

  always_comb begin
    sel_period = soft_drop ? (gamespeed >> SOFT_SHIFT) : gamespeed;
    if (sel_period < MIN_PERIOD) sel_period = MIN_PERIOD;
  end

  // >= rather than == lets a shrinking period fire at once instead of wrapping.
  always_ff @(posedge clk_25_175 or posedge reset) begin
    if (reset) begin
      period    <= MIN_PERIOD;
      counter   <= '0;
      drop_tick <= 1'b0;
    end else begin
      period <= sel_period;
      if (piece_locked) begin
        counter   <= '0;
        drop_tick <= 1'b0;
      end else if (pause) begin
        drop_tick <= 1'b0;
      end else if (counter >= period - GS_W'(1)) begin
        counter   <= '0;
        drop_tick <= 1'b1;
      end else begin
        counter   <= counter + GS_W'(1);
        drop_tick <= 1'b0;
      end
    end
  end

  bump_serializer #(
    .PEND_W   (PEND_W),
    .BUMP_GAP (BUMP_GAP)
  ) u_bump_serializer (
    .clk_25_175    (clk_25_175),
    .reset         (reset),
    .pause         (pause),
    .lines_valid   (lines_valid),
    .lines_cleared (lines_cleared),
    .bump          (bump),
    .bump_pending  (bump_pending),
    .overflow      (overflow)
  );

endmodule
